uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, transmit FIFO entries; power of two, 2..16.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 TxD_start  input  1  write strobe; one byte offered per cycle high.
REQ-006 TxD_data  input  8  byte sampled with TxD_start.
REQ-007 TxD  output  1  serial line; 8N1 framing, LSB first, idle high.
REQ-008 full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-009 busy  output  1  frame in progress or FIFO non-empty.
REQ-010 count  output  5  FIFO occupancy, 0..FIFO_DEPTH.
REQ-011 overflow  output  1  sticky; a write was dropped.
REQ-012 tx_done  output  1  one-cycle pulse at the end of each stop bit.

Function
REQ-013 Write accepted when TxD_start=1 and full=0; the byte is pushed at that edge.
REQ-014 Write with full=1 is dropped, FIFO unchanged, overflow set to 1 at that edge; full is evaluated before any same-cycle pop.
REQ-015 FIFO is strict first-in first-out; read/write pointers wrap modulo FIFO_DEPTH.
REQ-016 count: +1 on accepted push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-017 FSM states: IDLE, START, DATA, STOP.
REQ-018 IDLE: TxD=1; if FIFO non-empty, pop the head byte into the shift register and enter START at the same edge.
REQ-019 START: TxD=0 for exactly CLKS_PER_BIT cycles, then DATA.
REQ-020 DATA: bits 0..7 driven in order, each for exactly CLKS_PER_BIT cycles; 3-bit bit counter; after bit 7, enter STOP.
REQ-021 STOP: TxD=1 for CLKS_PER_BIT cycles; tx_done=1 during the final cycle.
REQ-022 STOP exit: if FIFO non-empty, pop and enter START with no idle cycle; otherwise enter IDLE.
REQ-023 Frame length is exactly 10*CLKS_PER_BIT cycles; baud counter reloads at every bit boundary.
REQ-024 Latency: push into an empty FIFO in IDLE at edge N -> pop at edge N+1 -> TxD=0 from edge N+1.
REQ-025 TxD is driven from a register; no combinational path from inputs to TxD.
REQ-026 busy = (state != IDLE) or (count != 0).
REQ-027 A push during a frame never disturbs the byte being shifted.

Reset
REQ-028 rst=1 at an edge forces state IDLE, TxD=1, count=0, full=0, busy=0, overflow=0, tx_done=0, pointers=0, baud and bit counters=0.
REQ-029 rst takes priority over any same-cycle TxD_start; that write is discarded.
REQ-030 rst mid-frame aborts the frame immediately (TxD=1 next cycle), flushes the FIFO, and emits no tx_done.
REQ-031 overflow clears only on rst.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-032 Single write 0xA5 in IDLE -> TxD over 40 cycles = 0,1,0,1,0,0,1,0,1,1 (each 4 cycles); tx_done pulses once at cycle 40; busy falls the next cycle.
REQ-033 Five writes of 0x01..0x05 on consecutive cycles from IDLE -> first popped at once; all five accepted (count peaks 4, full=1); five frames back-to-back in 200 cycles with no idle gap; overflow=0.
REQ-034 Six consecutive writes -> sixth dropped, overflow=1 and stays 1; exactly five frames sent.
REQ-035 With full=1 and a pop in the same cycle as TxD_start -> write dropped, overflow=1, count drops 4->3.
REQ-036 rst asserted at cycle 15 of a frame with 2 bytes queued -> TxD=1, count=0, busy=0 next cycle; no tx_done; line stays idle.
REQ-037 Random writes against a reference byte-queue model -> decoded serial stream matches accepted bytes exactly, in order.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 framing, LSB first, idle-high line, fed from a
// small byte FIFO so a host can queue several bytes and get back-to-back
// frames with no idle gap between them.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       TxD_start,
  input  logic [7:0] TxD_data,
  output logic       TxD,
  output logic       full,
  output logic       busy,
  output logic [4:0] count,
  output logic       overflow,
  output logic       tx_done
);

  localparam int          PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [4:0]  DEPTH_C   = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic [15:0]        baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               txd_q, txd_d;
  logic [4:0]         count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         mem_q [FIFO_DEPTH];

  logic               push;
  logic               drop;
  logic               pop;
  logic               baud_end;
  logic [7:0]         head;

  // Fullness is taken from the registered count, so a write in the same
  // cycle as a pop from a full FIFO is still refused.
  assign full     = (count_q == DEPTH_C);
  assign push     = TxD_start && !full;
  assign drop     = TxD_start && full;
  assign head     = mem_q[rd_ptr_q];
  assign baud_end = (baud_q == BAUD_LAST);

  assign TxD      = txd_q;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != IDLE) || (count_q != 5'd0);
  assign tx_done  = (state_q == STOP) && baud_end;

  // Frame sequencer: next state, baud/bit counters, shift register, line level.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        txd_d  = 1'b1;
        baud_d = 16'd0;
        bit_d  = 3'd0;
        if (count_q != 5'd0) begin
          pop     = 1'b1;
          shift_d = head;
          txd_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = 16'd0;
          bit_d   = 3'd0;
          txd_d   = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = 16'd0;
          if (bit_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = shift_q[bit_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = 16'd0;
          bit_d  = 3'd0;
          // Chain straight into the next frame when bytes are waiting.
          if (count_q != 5'd0) begin
            pop     = 1'b1;
            shift_d = head;
            txd_d   = 1'b0;
            state_d = START;
          end else begin
            txd_d   = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        txd_d   = 1'b1;
        baud_d  = 16'd0;
        bit_d   = 3'd0;
        state_d = IDLE;
      end
    endcase
  end

  // FIFO bookkeeping: pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + 5'd1;
    end else if (pop && !push) begin
      count_d = count_q - 5'd1;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  // Control registers; reset aborts any frame and flushes the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= 16'd0;
      bit_q    <= 3'd0;
      txd_q    <= 1'b1;
      count_q  <= 5'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      txd_q    <= txd_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Data storage; contents are only meaningful behind valid pointers/count.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= TxD_data;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4: a frame-position
// reference model checked every cycle, a serial decoder checked against the
// accepted-byte list, and directed cases with literal expectations.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       TxD_start = 1'b0;
  logic [7:0] TxD_data = 8'h00;
  logic       TxD;
  logic       full;
  logic       busy;
  logic [4:0] count;
  logic       overflow;
  logic       tx_done;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .TxD_start(TxD_start), .TxD_data(TxD_data),
    .TxD(TxD), .full(full), .busy(busy), .count(count),
    .overflow(overflow), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Reference model state: queue of waiting bytes, frame in flight and its position.
  logic [7:0] mq[$];
  logic [7:0] acc_q[$];
  bit         m_active = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_ovf = 1'b0;
  bit         m_was_full = 1'b0;
  bit         model_ok = 1'b0;

  function automatic logic exp_txd(input bit act, input int pos, input logic [7:0] b);
    int idx;
    if (!act) return 1'b1;
    idx = pos / CPB;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_ovf    = 1'b0;
      model_ok = 1'b1;
    end else begin
      m_was_full = (mq.size() == DEPTH);
      if (m_active) begin
        if (m_pos == FRAME - 1) begin
          if (mq.size() > 0) begin
            m_cur = mq.pop_front();
            m_pos = 0;
          end else begin
            m_active = 1'b0;
          end
        end else begin
          m_pos++;
        end
      end else if (mq.size() > 0) begin
        m_cur    = mq.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
      end
      if (TxD_start) begin
        if (!m_was_full) begin
          mq.push_back(TxD_data);
          acc_q.push_back(TxD_data);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  // Per-cycle output compare plus an independent serial-line decoder.
  bit         d_on = 1'b0;
  int         d_t = 0;
  logic [7:0] d_byte = 8'h00;
  int         d_idx = 0;
  int         frames = 0;
  logic [9:0] ev, av;
  logic [8:0] exp_rx;

  always @(negedge clk) begin
    if (model_ok) begin
      av = {TxD, tx_done, busy, full, overflow, count};
      ev = {exp_txd(m_active, m_pos, m_cur), (m_active && m_pos == FRAME - 1),
            (m_active || mq.size() != 0), (mq.size() == DEPTH), m_ovf, 5'(mq.size())};
      checks++;
      if (av !== ev) begin
        errors++;
        $display("FAIL cycle_cmp at %0t: actual {TxD,done,busy,full,ovf,count}=%b required=%b",
                 $time, av, ev);
      end
      if (rst) begin
        d_on  = 1'b0;
        d_idx = acc_q.size();
      end else if (!d_on) begin
        if (TxD == 1'b0) begin
          d_on = 1'b1;
          d_t  = 0;
        end
      end else begin
        d_t++;
        if (d_t >= 6 && d_t <= 34 && (d_t % CPB) == 2) d_byte[(d_t - 6) / CPB] = TxD;
        if (d_t == 38) begin
          chk("rx_stop_bit", TxD, 1);
          exp_rx = (d_idx < acc_q.size()) ? {1'b0, acc_q[d_idx]} : 9'h100;
          chk("rx_byte", {1'b0, d_byte}, exp_rx);
          d_idx++;
          frames++;
        end
        if (d_t == FRAME - 1) d_on = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [7:0] b);
    TxD_start = 1'b1;
    TxD_data  = b;
    tick();
    TxD_start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    chk("drain_timeout", busy, 0);
    tick();
    tick();
  endtask

  int a5_bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

  initial begin
    int npulse, pulse_at, f0, lows, n;
    rst = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_txd", TxD, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_done", tx_done, 0);

    // Single 0xA5 frame with literal line levels.
    write(8'hA5);
    npulse = 0;
    pulse_at = -1;
    for (int k = 1; k <= FRAME; k++) begin
      tick();
      chk("a5_line", TxD, a5_bits[(k - 1) / CPB]);
      if (tx_done) begin
        npulse++;
        pulse_at = k;
      end
    end
    chk("a5_pulses", npulse, 1);
    chk("a5_pulse_cycle", pulse_at, 40);
    tick();
    chk("a5_busy_after", busy, 0);
    chk("a5_idle_line", TxD, 1);

    // Five consecutive writes: all accepted, FIFO reaches full.
    f0 = frames;
    for (int i = 1; i <= 5; i++) write(8'(i));
    chk("five_count", count, 4);
    chk("five_full", full, 1);
    chk("five_ovf", overflow, 0);
    wait_idle(6 * FRAME);
    chk("five_frames", frames - f0, 5);
    chk("five_ovf_end", overflow, 0);

    // Six consecutive writes: sixth dropped, overflow sticks.
    f0 = frames;
    for (int i = 0; i < 6; i++) write(8'h40 + 8'(i));
    chk("six_ovf", overflow, 1);
    chk("six_count", count, 4);
    wait_idle(6 * FRAME);
    chk("six_frames", frames - f0, 5);
    chk("six_ovf_sticky", overflow, 1);

    // Write while full in the same cycle as a pop.
    do_reset();
    chk("ovf_cleared", overflow, 0);
    f0 = frames;
    for (int i = 0; i < 5; i++) write(8'h11 + 8'(i));
    n = 0;
    while (!tx_done && n < 2 * FRAME) begin
      tick();
      n++;
    end
    chk("pop_edge_seen", tx_done, 1);
    chk("pop_edge_count", count, 4);
    chk("pop_edge_full", full, 1);
    write(8'hEE);
    chk("pop_drop_ovf", overflow, 1);
    chk("pop_drop_count", count, 3);
    wait_idle(6 * FRAME);
    chk("pop_frames", frames - f0, 5);

    // Reset mid-frame with two bytes queued, plus a write under reset.
    do_reset();
    write(8'h31);
    write(8'h32);
    write(8'h33);
    chk("mid_queued", count, 2);
    repeat (13) tick();
    rst = 1'b1;
    TxD_start = 1'b1;
    TxD_data = 8'h99;
    tick();
    rst = 1'b0;
    TxD_start = 1'b0;
    chk("mid_txd", TxD, 1);
    chk("mid_count", count, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", tx_done, 0);
    lows = 0;
    npulse = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (!TxD) lows++;
      if (tx_done) npulse++;
    end
    chk("mid_line_lows", lows, 0);
    chk("mid_pulses", npulse, 0);
    chk("mid_busy_end", busy, 0);

    // Random traffic: dense bursts then sparse writes.
    for (int i = 0; i < 600; i++) begin
      if (i < 200) TxD_start = ($urandom_range(0, 2) == 0);
      else         TxD_start = ($urandom_range(0, 39) == 0);
      TxD_data = 8'($urandom_range(0, 255));
      tick();
    end
    TxD_start = 1'b0;
    wait_idle(6 * FRAME);
    chk("all_decoded", d_idx, acc_q.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
